snn_dense_layer_tm: RTL and testbench



---
 rtl/snn_pkg.sv | 25 ++
 rtl/snn_dense_layer_tm_if.sv | 28 ++
 rtl/snn_lif_unit.sv | 61 ++++++
 rtl/snn_dense_layer_tm.sv | 89 ++++++++
 tb/tb_snn_dense_layer_tm.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed LIF dense layer.
//   state_t : controller FSM states
//   acc_w   : membrane/accumulator width derived from weight width and fan-in
//   sat_add : signed add clamped to a w-bit two's-complement range
package snn_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FIRE, S_OUT} state_t;

  function automatic int acc_w(input int width, input int in_size);
    return width + $clog2(in_size + 1) + 2;
  endfunction

  // Operands are sign-extended to 64 bits, so the raw sum cannot overflow for
  // any realistic w; the clamp then maps it back into the w-bit range.
  function automatic longint sat_add(input longint a, input longint b, input int w);
    longint hi, lo, s;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    s  = a + b;
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return s;
  endfunction

endpackage

// File: rtl/snn_dense_layer_tm_if.sv
// Spike-vector handshake bundle for one dense layer.
//   in_valid/in_ready/in_spikes/layer_clear : upstream timestep channel
//   out_valid/out_ready/out_spikes          : downstream spike channel
//   layer_done                              : pulse on output handshake
// master = upstream/downstream side, slave = the layer itself.
interface snn_dense_layer_tm_if #(
  parameter int NEURON_NB = 4,
  parameter int IN_SIZE   = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_SIZE-1:0]   in_spikes;
  logic                 layer_clear;
  logic                 out_valid;
  logic                 out_ready;
  logic [NEURON_NB-1:0] out_spikes;
  logic                 layer_done;

  modport master (
    output in_valid, in_spikes, layer_clear, out_ready,
    input  in_ready, out_valid, out_spikes, layer_done
  );

  modport slave (
    input  in_valid, in_spikes, layer_clear, out_ready,
    output in_ready, out_valid, out_spikes, layer_done
  );
endinterface

// File: rtl/snn_lif_unit.sv
// One leaky integrate-and-fire neuron: accumulator, persistent membrane, fire.
//   load   : start of timestep, acc <= sat(leak(v') + bias), v' = 0 if clear
//   clear  : zero the membrane
//   add_en : acc <= sat(acc + weight) (current input spiked)
//   fire   : compare against THRESH, register spike, update membrane
//   spike  : registered fire decision, held until the next fire
module snn_lif_unit
  import snn_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int ACC_W      = 9,
  parameter int THRESH     = 8,
  parameter int LEAK_SHIFT = 0,
  parameter int RESET_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    clear,
  input  logic                    add_en,
  input  logic signed [WIDTH-1:0] weight,
  input  logic signed [WIDTH-1:0] bias,
  input  logic                    fire,
  output logic                    spike
);

  localparam logic signed [ACC_W-1:0] TH = ACC_W'(THRESH);

  logic signed [ACC_W-1:0] acc, v, v_src, v_lk;
  logic                    fires;

  // v - (v >>> s) lies between 0 and v, so the leak step itself never
  // overflows; only the bias add needs clamping.
  always_comb begin
    v_src = clear ? '0 : v;
    v_lk  = (LEAK_SHIFT == 0) ? v_src : v_src - (v_src >>> LEAK_SHIFT);
    fires = (acc >= TH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      v     <= '0;
      spike <= 1'b0;
    end else begin
      if (load)
        acc <= ACC_W'(sat_add(longint'(v_lk), longint'(bias), ACC_W));
      else if (add_en)
        acc <= ACC_W'(sat_add(longint'(acc), longint'(weight), ACC_W));

      if (clear)
        v <= '0;
      else if (fire) begin
        spike <= fires;
        // acc >= TH > 0 when firing, so acc - TH stays in range
        v <= fires ? ((RESET_MODE != 0) ? acc - TH : '0) : acc;
      end
    end
  end

endmodule

// File: rtl/snn_dense_layer_tm.sv
// Time-multiplexed binary-spike dense layer of NEURON_NB LIF neurons.
// Each timestep: bias/leak load (IDLE accept), IN_SIZE serial accumulate
// cycles, one fire cycle, then the spike vector is held on the output
// channel until accepted.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : handshake bundle (slave side)
//   weights    : neuron n, input i at [(n*IN_SIZE+i)*WIDTH +: WIDTH], signed
//   biases     : neuron n at [n*WIDTH +: WIDTH], signed
module snn_dense_layer_tm
  import snn_pkg::*;
#(
  parameter int NEURON_NB  = 4,
  parameter int IN_SIZE    = 4,
  parameter int WIDTH      = 4,
  parameter int THRESH     = 8,
  parameter int LEAK_SHIFT = 0,
  parameter int RESET_MODE = 0,
  parameter int ACC_W      = acc_w(WIDTH, IN_SIZE)
) (
  input logic                                clk,
  input logic                                reset,
  snn_dense_layer_tm_if.slave                bus,
  input logic [NEURON_NB*IN_SIZE*WIDTH-1:0]  weights,
  input logic [NEURON_NB*WIDTH-1:0]          biases
);

  localparam int IDX_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

  state_t               state, state_nx;
  logic [IDX_W-1:0]     idx;
  logic [IN_SIZE-1:0]   spk_lat;
  logic [NEURON_NB-1:0] spk_vec;
  logic                 accept, last_idx, clear, add_en, fire;

  assign accept   = (state == S_IDLE) && bus.in_valid;
  assign clear    = (state == S_IDLE) && bus.layer_clear;
  assign last_idx = (idx == IDX_W'(IN_SIZE - 1));
  assign add_en   = (state == S_ACCUM) && spk_lat[idx];
  assign fire     = (state == S_FIRE);

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.out_valid  = (state == S_OUT);
  assign bus.layer_done = (state == S_OUT) && bus.out_ready;
  assign bus.out_spikes = spk_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      spk_lat <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        spk_lat <= bus.in_spikes;
        idx     <= '0;
      end else if (state == S_ACCUM) begin
        idx <= last_idx ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // ACCUM always runs IN_SIZE cycles regardless of spike density, so the
  // timestep period is fixed.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.in_valid)  state_nx = S_ACCUM;
      S_ACCUM: if (last_idx)      state_nx = S_FIRE;
      S_FIRE:                     state_nx = S_OUT;
      S_OUT:   if (bus.out_ready) state_nx = S_IDLE;
      default:                    state_nx = S_IDLE;
    endcase
  end

  for (genvar n = 0; n < NEURON_NB; n++) begin : g_lane
    logic [IN_SIZE-1:0][WIDTH-1:0] w_row;
    assign w_row = weights[n*IN_SIZE*WIDTH +: IN_SIZE*WIDTH];

    snn_lif_unit #(
      .WIDTH(WIDTH), .ACC_W(ACC_W), .THRESH(THRESH),
      .LEAK_SHIFT(LEAK_SHIFT), .RESET_MODE(RESET_MODE)
    ) u_lif (
      .clk(clk), .rst(reset), .load(accept), .clear(clear), .add_en(add_en),
      .weight(w_row[idx]), .bias(biases[n*WIDTH +: WIDTH]),
      .fire(fire), .spike(spk_vec[n])
    );
  end

endmodule

// File: tb/tb_snn_dense_layer_tm.sv
// Four layer instances run in lockstep on shared handshake inputs:
//   d0: THRESH 8, reset-to-zero      d1: THRESH 8, reset-by-subtraction
//   d2: THRESH 8, LEAK_SHIFT 1       d3: THRESH 255 (max), weights/bias +7
// A behavioural model pushes expected spike vectors into a scoreboard that is
// drained on each output handshake; membranes/accumulators are peeked too.
module tb_snn_dense_layer_tm;

  localparam int ND = 4;

  logic clk, reset;
  logic in_valid, layer_clear, out_ready;
  logic [3:0] in_spikes;
  logic [ND-1:0] ir, ov, ld;
  logic [ND-1:0][1:0] os;
  logic [ND-1:0][1:0][8:0] mem, accp;
  logic [ND-1:0][31:0] wts;
  logic [ND-1:0][7:0] bs;

  int n_tests = 0, n_fail = 0, n_done = 0, n_steps = 0;
  logic [7:0] sb[$];
  int mv[ND][2], ma[ND][2], wm[ND][2][4], bm[ND][2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    snn_dense_layer_tm_if #(.NEURON_NB(2), .IN_SIZE(4)) bus ();
    assign bus.in_valid    = in_valid;
    assign bus.in_spikes   = in_spikes;
    assign bus.layer_clear = layer_clear;
    assign bus.out_ready   = out_ready;
    assign ir[d] = bus.in_ready;
    assign ov[d] = bus.out_valid;
    assign os[d] = bus.out_spikes;
    assign ld[d] = bus.layer_done;

    snn_dense_layer_tm #(
      .NEURON_NB(2), .IN_SIZE(4), .WIDTH(4),
      .THRESH((d == 3) ? 255 : 8),
      .LEAK_SHIFT((d == 2) ? 1 : 0),
      .RESET_MODE((d == 1) ? 1 : 0)
    ) dut (
      .clk(clk), .reset(reset), .bus(bus), .weights(wts[d]), .biases(bs[d])
    );

    assign mem[d][0]  = dut.g_lane[0].u_lif.v;
    assign mem[d][1]  = dut.g_lane[1].u_lif.v;
    assign accp[d][0] = dut.g_lane[0].u_lif.acc;
    assign accp[d][1] = dut.g_lane[1].u_lif.acc;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sv9(input logic [8:0] x);
    return int'($signed(x));
  endfunction

  function automatic int sat9(input int x);
    if (x > 255) return 255;
    if (x < -256) return -256;
    return x;
  endfunction

  function automatic int th_of(input int d); return (d == 3) ? 255 : 8; endfunction
  function automatic int lk_of(input int d); return (d == 2) ? 1 : 0; endfunction
  function automatic int rm_of(input int d); return (d == 1) ? 1 : 0; endfunction

  // Expected behaviour of one timestep for every instance and neuron.
  task automatic model(input logic [3:0] sp, input logic clr, output logic [7:0] e);
    int v, a;
    e = '0;
    for (int d = 0; d < ND; d++)
      for (int n = 0; n < 2; n++) begin
        v = clr ? 0 : mv[d][n];
        if (lk_of(d) != 0) v = v - (v >>> lk_of(d));
        a = sat9(v + bm[d][n]);
        for (int i = 0; i < 4; i++)
          if (sp[i]) a = sat9(a + wm[d][n][i]);
        ma[d][n] = a;
        e[2*d+n] = (a >= th_of(d));
        mv[d][n] = e[2*d+n] ? ((rm_of(d) != 0) ? a - th_of(d) : 0) : a;
      end
  endtask

  task automatic zero_model();
    for (int d = 0; d < ND; d++)
      for (int n = 0; n < 2; n++) begin
        mv[d][n] = 0;
        ma[d][n] = 0;
      end
  endtask

  task automatic chk_state();
    for (int d = 0; d < ND; d++)
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("mem%0d_%0d", d, n), sv9(mem[d][n]), mv[d][n]);
        chk($sformatf("acc%0d_%0d", d, n), sv9(accp[d][n]), ma[d][n]);
      end
  endtask

  // Called at posedge+#1 with all instances in IDLE; returns likewise.
  task automatic step(input logic [3:0] sp, input logic clr, input int hold);
    logic [7:0] e;
    int cnt;
    model(sp, clr, e);
    sb.push_back(e);
    n_steps++;
    chk("in_ready", ir, 4'hF);
    in_spikes = sp; layer_clear = clr; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; layer_clear = 1'b0;
    cnt = 0;
    while (!ov[0] && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", cnt, 5);
    for (int c = 0; c < hold; c++) begin
      in_valid = c[0]; layer_clear = ~c[0]; in_spikes = 4'($urandom);
      @(posedge clk); #1;
      chk("bp_valid", ov, 4'hF);
      chk("bp_ready", ir, 0);
      chk("bp_spk", os, e);
    end
    in_valid = 1'b0; layer_clear = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_idle", ir, 4'hF);
    chk_state();
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset) begin
      for (int d = 0; d < ND; d++)
        chk($sformatf("done%0d", d), ld[d], ov[d] & out_ready);
      if (ld[0]) n_done++;
      if (ov[0] && out_ready) begin
        if (sb.size() == 0) chk("sb_under", sb.size(), 1);
        else begin
          e = sb.pop_front();
          for (int d = 0; d < ND; d++) begin
            chk($sformatf("ov%0d", d), ov[d], 1);
            chk($sformatf("spk%0d", d), os[d], e[2*d +: 2]);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_spikes = '0; layer_clear = 1'b0; out_ready = 1'b1;
    for (int d = 0; d < ND; d++)
      for (int n = 0; n < 2; n++) begin
        bm[d][n] = (d == 3) ? 7 : 0;
        bs[d][n*4 +: 4] = bm[d][n][3:0];
        for (int i = 0; i < 4; i++) begin
          wm[d][n][i] = (d == 3) ? 7 : ((n == 0) ? 3 : -2);
          wts[d][(n*4+i)*4 +: 4] = wm[d][n][i][3:0];
        end
      end
    zero_model();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", ir, 4'hF);
    chk("rst_out_valid", ov, 0);
    chk("rst_out_spikes", os, 0);
    chk("rst_layer_done", ld, 0);
    chk_state();
    reset = 1'b0;
    @(posedge clk); #1;

    // basic fire, reset-to-zero vs reset-by-subtraction
    step(4'b1111, 1'b0, 0);
    chk("d0_v0", sv9(mem[0][0]), 0);
    chk("d0_v1", sv9(mem[0][1]), -8);
    chk("d1_v0", sv9(mem[1][0]), 4);
    // silent timesteps: no change without leak, leak decays toward zero
    step(4'b0000, 1'b0, 0);
    chk("d1_v0_quiet", sv9(mem[1][0]), 4);
    chk("d2_leak1", sv9(mem[2][1]), -4);
    step(4'b0000, 1'b0, 0);
    chk("d2_leak2", sv9(mem[2][1]), -2);
    step(4'b0000, 1'b0, 0);
    chk("d2_leak3", sv9(mem[2][1]), -1);
    step(4'b0000, 1'b0, 0);
    step(4'b0011, 1'b0, 0);
    chk("d1_v0_sub", sv9(mem[1][0]), 2);

    // all-ones drives d3 into positive saturation; one step under backpressure
    step(4'b1111, 1'b0, 0);
    step(4'b1111, 1'b0, 10);
    step(4'b1111, 1'b0, 0);
    step(4'b1111, 1'b0, 0);
    step(4'b1111, 1'b0, 0);
    chk("d3_sat_acc", sv9(accp[3][0]), 255);
    chk("d3_sat_v", sv9(mem[3][0]), 0);

    // reset during ACCUM aborts the timestep
    in_spikes = 4'b1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    zero_model();
    chk("abort_in_ready", ir, 4'hF);
    chk("abort_out_valid", ov, 0);
    chk_state();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("abort_no_out", ov, 0);
    end

    // layer_clear alone in IDLE, then a timestep starting from bias only
    step(4'b1111, 1'b0, 0);
    layer_clear = 1'b1;
    @(posedge clk); #1;
    layer_clear = 1'b0;
    zero_model();
    chk("clr_d3_v0", sv9(mem[3][0]), 0);
    chk("clr_d0_v1", sv9(mem[0][1]), 0);
    step(4'b0000, 1'b0, 0);
    chk("clr_bias_only", sv9(accp[3][0]), 7);
    step(4'b0101, 1'b0, 0);
    step(4'b1111, 1'b1, 0);
    step(4'b1111, 1'b0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("done_count", n_done, n_steps);
    chk("sb_left", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
